// File: rtl/heap_pkg.sv
// heap_pkg: shared definitions for heap_arbiter and its sub-blocks.
// Contents:
//   - requester op encodings (OP_*)
//   - heap instruction encodings (HEAP_*)
//   - arbiter FSM state type
//   - watchdog error signature (used by the optional HEAP_ARB_TIMEOUT_EN build)
//   - op_to_instr helper
package heap_pkg;

    localparam logic [1:0] OP_COUNT = 2'b00;
    localparam logic [1:0] OP_PUSH  = 2'b01;
    localparam logic [1:0] OP_POP   = 2'b10;
    localparam logic [1:0] OP_PEEK  = 2'b11;

    localparam logic [1:0] HEAP_NOP  = 2'b00;
    localparam logic [1:0] HEAP_PUSH = 2'b01;
    localparam logic [1:0] HEAP_POP  = 2'b10;

    // The low two bits carry the op that timed out.
    localparam logic [31:0] TIMEOUT_SIG = 32'hDEAD_0000;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StIssue,
        StWait,
        StSettle,
        StResp
    } arb_state_e;

    // Only push and pop ever reach the heap.
    function automatic logic [1:0] op_to_instr(input logic [1:0] op);
        return (op == OP_PUSH) ? HEAP_PUSH : HEAP_POP;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant.
// The search starts at ptr_i+1 and wraps, so the requester at ptr_i has the
// lowest priority.
// Ports:
//   req_i  [NUM_REQ]  request vector
//   ptr_i  [IdxW]     index of the last granted requester
//   gnt_o  [NUM_REQ]  one-hot grant (all zero when no request)
//   idx_o  [IdxW]     encoded grant index (0 when no request)
//   any_o             at least one request is pending
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IdxW   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IdxW-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IdxW-1:0]    idx_o,
    output logic               any_o
);

    logic [IdxW-1:0] cand;
    logic            found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            cand = IdxW'((int'(ptr_i) + k) % int'(NUM_REQ));
            if (!found && req_i[cand]) begin
                found        = 1'b1;
                gnt_o[cand]  = 1'b1;
                idx_o        = cand;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/heap_arbiter.sv
// heap_arbiter: shares one heap_control priority queue between NUM_REQ
// requesters. Commands (count/push/pop/peek) are accepted round-robin over
// valid/ready, checked against the current occupancy, issued to the heap if
// needed, and answered with a one-cycle rsp_valid pulse to the owner.
// Ports:
//   clk_i, reset_ni            clock, asynchronous active-low reset
//   req_valid_i/req_ready_o    per-requester handshake (ready is one-hot or 0)
//   req_op_i                   2 bits per requester: 00 count 01 push 10 pop 11 peek
//   req_key_i                  KEY_W bits per requester, push key
//   rsp_valid_o                one-cycle pulse to the owner
//   rsp_data_o/rsp_err_o       response, held between responses
//   heap_start_o/heap_instr_o/heap_key_o   heap command interface
//   heap_done_i/heap_n_i/heap_root_i       heap status
//   timeout_flag_o             sticky watchdog flag (HEAP_ARB_TIMEOUT_EN only)
// Build option: define HEAP_ARB_TIMEOUT_EN to add a WAIT watchdog of
// TIMEOUT_CYC cycles and the timeout_flag_o port.
module heap_arbiter
    import heap_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned KEY_W       = 32,
    parameter int unsigned CNT_W       = 10,
    parameter int unsigned DEPTH       = 1023,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [2*NUM_REQ-1:0]     req_op_i,
    input  logic [KEY_W*NUM_REQ-1:0] req_key_i,
    output logic [NUM_REQ-1:0]       rsp_valid_o,
    output logic [KEY_W-1:0]         rsp_data_o,
    output logic                     rsp_err_o,
    output logic                     heap_start_o,
    output logic [1:0]               heap_instr_o,
    output logic [KEY_W-1:0]         heap_key_o,
    input  logic                     heap_done_i,
    input  logic [CNT_W-1:0]         heap_n_i,
    input  logic [KEY_W-1:0]         heap_root_i
`ifdef HEAP_ARB_TIMEOUT_EN
    ,
    output logic                     timeout_flag_o
`endif
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    arb_state_e       state_q, state_d;
    logic [IdxW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]  owner_q, owner_d;
    logic [1:0]       op_q, op_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [KEY_W-1:0] root_cache_q, root_cache_d;
    // Result computed in CHECK, published on entry to RESP.
    logic [KEY_W-1:0] res_data_q, res_data_d;
    logic             res_err_q, res_err_d;
    logic [KEY_W-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;

    logic [NUM_REQ-1:0] gnt;
    logic [IdxW-1:0]    gnt_idx;
    logic               any_req;
    logic               accept;
    logic               heap_empty;
    logic               heap_full;

`ifdef HEAP_ARB_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYC + 1);
    logic [WdW-1:0] wd_cnt_q, wd_cnt_d;
    logic           timeout_q, timeout_d;
`else
    logic unused_cfg;
    assign unused_cfg = ^{TIMEOUT_CYC, TIMEOUT_SIG};
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req_i (req_valid_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (any_req)
    );

    assign req_ready_o = (state_q == StIdle) ? gnt : '0;
    assign accept      = any_req && |(req_valid_i & req_ready_o);
    assign heap_empty  = (heap_n_i == '0);
    assign heap_full   = (heap_n_i == CNT_W'(DEPTH));

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        op_d         = op_q;
        key_d        = key_q;
        root_cache_d = root_cache_q;
        res_data_d   = res_data_q;
        res_err_d    = res_err_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
`ifdef HEAP_ARB_TIMEOUT_EN
        wd_cnt_d     = wd_cnt_q;
        timeout_d    = timeout_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    rr_ptr_d = gnt_idx;
                    owner_d  = gnt_idx;
                    op_d     = req_op_i[int'(gnt_idx) * 2 +: 2];
                    key_d    = req_key_i[int'(gnt_idx) * int'(KEY_W) +: KEY_W];
                    state_d  = StCheck;
                end
            end

            StCheck: begin
                res_err_d  = 1'b0;
                res_data_d = '0;
                state_d    = StResp;
                unique case (op_q)
                    OP_COUNT: res_data_d = KEY_W'(heap_n_i);
                    OP_PEEK: begin
                        if (heap_empty) res_err_d = 1'b1;
                        else            res_data_d = root_cache_q;
                    end
                    OP_PUSH: begin
                        if (heap_full) res_err_d = 1'b1;
                        else           state_d = StIssue;
                    end
                    OP_POP: begin
                        if (heap_empty) begin
                            res_err_d = 1'b1;
                        end else begin
                            // Pop returns the max as it was before removal.
                            res_data_d = root_cache_q;
                            state_d    = StIssue;
                        end
                    end
                    default: ;
                endcase
                if (state_d == StResp) begin
                    rsp_data_d = res_data_d;
                    rsp_err_d  = res_err_d;
                end
            end

            StIssue: begin
`ifdef HEAP_ARB_TIMEOUT_EN
                wd_cnt_d = '0;
`endif
                state_d = StWait;
            end

            StWait: begin
                if (heap_done_i) begin
                    state_d = StSettle;
                end
`ifdef HEAP_ARB_TIMEOUT_EN
                else if (wd_cnt_q == WdW'(TIMEOUT_CYC - 1)) begin
                    timeout_d  = 1'b1;
                    rsp_err_d  = 1'b1;
                    rsp_data_d = KEY_W'(TIMEOUT_SIG | {30'd0, op_q});
                    state_d    = StResp;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
`endif
            end

            StSettle: begin
                // heap_root is only meaningful one cycle after done.
                root_cache_d = heap_empty ? '0 : heap_root_i;
                rsp_data_d   = res_data_q;
                rsp_err_d    = res_err_q;
                state_d      = StResp;
            end

            StResp: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= StIdle;
            rr_ptr_q     <= IdxW'(NUM_REQ - 1);
            owner_q      <= '0;
            op_q         <= OP_COUNT;
            key_q        <= '0;
            root_cache_q <= '0;
            res_data_q   <= '0;
            res_err_q    <= 1'b0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            op_q         <= op_d;
            key_q        <= key_d;
            root_cache_q <= root_cache_d;
            res_data_q   <= res_data_d;
            res_err_q    <= res_err_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

`ifdef HEAP_ARB_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_flag_o = timeout_q;
`endif

    always_comb begin
        rsp_valid_o = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            rsp_valid_o[i] = (state_q == StResp) && (owner_q == IdxW'(i));
        end
    end

    // Instruction and key stay stable from ISSUE until WAIT exits.
    assign heap_start_o = (state_q == StIssue);
    assign heap_instr_o = ((state_q == StIssue) || (state_q == StWait)) ?
                          op_to_instr(op_q) : HEAP_NOP;
    assign heap_key_o   = ((state_q == StIssue) || (state_q == StWait)) ? key_q : '0;
    assign rsp_data_o   = rsp_data_q;
    assign rsp_err_o    = rsp_err_q;

endmodule

// File: tb/tb_heap_arbiter.sv
// tb_heap_arbiter: directed bench for heap_arbiter with a behavioural max-heap
// (fixed 3-cycle busy time) standing in for heap_control. DEPTH is reduced to 7.
// Define HEAP_ARB_TIMEOUT_EN to include the watchdog scenario.
module tb_heap_arbiter;

    localparam int unsigned NUM_REQ     = 4;
    localparam int unsigned KEY_W       = 32;
    localparam int unsigned CNT_W       = 10;
    localparam int unsigned DEPTH       = 7;
    localparam int unsigned TIMEOUT_CYC = 16;

    localparam logic [1:0] OP_COUNT = 2'b00;
    localparam logic [1:0] OP_PUSH  = 2'b01;
    localparam logic [1:0] OP_POP   = 2'b10;
    localparam logic [1:0] OP_PEEK  = 2'b11;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b1;
    logic [NUM_REQ-1:0]       req_valid = '0;
    logic [NUM_REQ-1:0]       req_ready;
    logic [2*NUM_REQ-1:0]     req_op = '0;
    logic [KEY_W*NUM_REQ-1:0] req_key = '0;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [KEY_W-1:0]         rsp_data;
    logic                     rsp_err;
    logic                     heap_start;
    logic [1:0]               heap_instr;
    logic [KEY_W-1:0]         heap_key;
    logic                     heap_done;
    logic [CNT_W-1:0]         heap_n;
    logic [KEY_W-1:0]         heap_root;
`ifdef HEAP_ARB_TIMEOUT_EN
    logic                     timeout_flag;
`endif

    int errors = 0;
    int checks = 0;

    heap_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .KEY_W       (KEY_W),
        .CNT_W       (CNT_W),
        .DEPTH       (DEPTH),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk_i        (clk),
        .reset_ni     (reset_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op_i     (req_op),
        .req_key_i    (req_key),
        .rsp_valid_o  (rsp_valid),
        .rsp_data_o   (rsp_data),
        .rsp_err_o    (rsp_err),
        .heap_start_o (heap_start),
        .heap_instr_o (heap_instr),
        .heap_key_o   (heap_key),
        .heap_done_i  (heap_done),
        .heap_n_i     (heap_n),
        .heap_root_i  (heap_root)
`ifdef HEAP_ARB_TIMEOUT_EN
        ,
        .timeout_flag_o (timeout_flag)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- behavioural heap ----------------
    logic [31:0] keys[$];
    logic        busy;
    int          lat_cnt;
    logic [1:0]  pend_instr;
    logic [31:0] pend_key;
    bit          stall = 1'b0;

    function automatic int max_idx();
        int m = 0;
        for (int i = 1; i < keys.size(); i++) if (keys[i] > keys[m]) m = i;
        return m;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            keys.delete();
            heap_n     <= '0;
            heap_root  <= '0;
            heap_done  <= 1'b0;
            busy       <= 1'b0;
            lat_cnt    <= 0;
            pend_instr <= 2'b00;
            pend_key   <= '0;
        end else begin
            heap_done <= 1'b0;
            if (heap_start) begin
                busy       <= 1'b1;
                lat_cnt    <= 2;
                pend_instr <= heap_instr;
                pend_key   <= heap_key;
            end else if (busy && !stall) begin
                if (lat_cnt == 0) begin
                    if (pend_instr == 2'b01) keys.push_back(pend_key);
                    else if (pend_instr == 2'b10 && keys.size() > 0) keys.delete(max_idx());
                    heap_n    <= CNT_W'(keys.size());
                    heap_root <= (keys.size() > 0) ? keys[max_idx()] : '0;
                    heap_done <= 1'b1;
                    busy      <= 1'b0;
                end else begin
                    lat_cnt <= lat_cnt - 1;
                end
            end
        end
    end

    // ---------------- observers ----------------
    int          start_cnt = 0;
    int          rsp_cnt = 0;
    logic [31:0] last_data [NUM_REQ];
    logic        last_err  [NUM_REQ];

    always @(posedge clk) if (reset_n && heap_start) start_cnt++;

    always @(negedge clk) begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (rsp_valid[i]) begin
                rsp_cnt++;
                last_data[i] = rsp_data;
                last_err[i]  = rsp_err;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one command from requester r and wait for its response.
    // lat counts cycles from the accept cycle to the rsp_valid cycle.
    task automatic cmd(input int r, input logic [1:0] op, input logic [31:0] key,
                       output logic [31:0] data, output logic err, output int lat);
        int w;
        bit got;
        @(negedge clk);
        req_valid[r]          = 1'b1;
        req_op[2*r +: 2]      = op;
        req_key[32*r +: 32]   = key;
        #1;
        w = 0;
        while (!req_ready[r] && w < 100) begin
            @(negedge clk);
            #1;
            w++;
        end
        @(posedge clk);
        #1;
        req_valid[r] = 1'b0;
        lat  = 0;
        got  = 1'b0;
        data = '0;
        err  = 1'b0;
        while (!got && lat < 200) begin
            @(negedge clk);
            lat++;
            if (rsp_valid[r]) begin
                got  = 1'b1;
                data = rsp_data;
                err  = rsp_err;
            end
        end
        chk("rsp_seen", 32'(got), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] d;
    logic        e;
    int          l;
    int          s0;
    int          r0;
    int          order[$];
    int          exp_order[5] = '{0, 1, 2, 3, 0};
    int          g;
    int          cyc;

    initial begin
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready",      32'(req_ready),  32'd0);
        chk("rst_rsp_valid",  32'(rsp_valid),  32'd0);
        chk("rst_rsp_data",   rsp_data,        32'd0);
        chk("rst_rsp_err",    32'(rsp_err),    32'd0);
        chk("rst_heap_start", 32'(heap_start), 32'd0);
        chk("rst_heap_instr", 32'(heap_instr), 32'd0);
        chk("rst_heap_key",   heap_key,        32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Empty heap: pop/peek rejected without touching the heap.
        cmd(0, OP_POP, 0, d, e, l);
        chk("empty_pop_err", 32'(e), 32'd1);
        chk("empty_pop_data", d, 32'd0);
        chk("empty_pop_lat", 32'(l), 32'd2);
        cmd(0, OP_PEEK, 0, d, e, l);
        chk("empty_peek_err", 32'(e), 32'd1);
        chk("empty_peek_data", d, 32'd0);
        chk("empty_no_start", 32'(start_cnt), 32'd0);

        // Single requester: push 5, 9, 3; pop -> 9; count -> 2; peek -> 5.
        cmd(0, OP_PUSH, 5, d, e, l);
        chk("push5_err", 32'(e), 32'd0);
        chk("push5_lat", 32'(l), 32'd8);
        cmd(0, OP_PUSH, 9, d, e, l);
        chk("push9_err", 32'(e), 32'd0);
        cmd(0, OP_PUSH, 3, d, e, l);
        cmd(0, OP_POP, 0, d, e, l);
        chk("pop_data", d, 32'd9);
        chk("pop_err", 32'(e), 32'd0);
        chk("pop_lat", 32'(l), 32'd8);
        cmd(0, OP_COUNT, 0, d, e, l);
        chk("count2", d, 32'd2);
        chk("count_lat", 32'(l), 32'd2);
        cmd(0, OP_PEEK, 0, d, e, l);
        chk("peek5", d, 32'd5);

        // Drain from requester 3 so the pointer sits at 3.
        cmd(3, OP_POP, 0, d, e, l);
        chk("drain_a", d, 32'd5);
        cmd(3, OP_POP, 0, d, e, l);
        chk("drain_b", d, 32'd3);

        // All four requesters push 1..4; requester 0 then re-requests a count.
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            req_valid[i]        = 1'b1;
            req_op[2*i +: 2]    = OP_PUSH;
            req_key[32*i +: 32] = 32'(i + 1);
        end
        cyc = 0;
        while (order.size() < 5 && cyc < 300) begin
            #1;
            if (|req_ready) begin
                g = 0;
                for (int i = 0; i < 4; i++) if (req_ready[i]) g = i;
                order.push_back(g);
                @(posedge clk);
                #1;
                if (order.size() == 1) req_op[1:0] = OP_COUNT;
                else                   req_valid[g] = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        req_valid = '0;
        repeat (6) @(negedge clk);
        chk("grant_count", 32'(order.size()), 32'd5);
        for (int i = 0; i < 5; i++) chk($sformatf("grant%0d", i), 32'(order[i]), 32'(exp_order[i]));
        chk("rr_count4", last_data[0], 32'd4);
        chk("rr_count_err", 32'(last_err[0]), 32'd0);
        cmd(2, OP_PEEK, 0, d, e, l);
        chk("rr_peek4", d, 32'd4);

        // Fill to DEPTH=7, then one more push is rejected.
        cmd(1, OP_PUSH, 10, d, e, l);
        cmd(1, OP_PUSH, 11, d, e, l);
        cmd(1, OP_PUSH, 12, d, e, l);
        chk("full_n", 32'(heap_n), 32'd7);
        s0 = start_cnt;
        cmd(1, OP_PUSH, 13, d, e, l);
        chk("full_err", 32'(e), 32'd1);
        chk("full_data", d, 32'd0);
        chk("full_lat", 32'(l), 32'd2);
        chk("full_n_held", 32'(heap_n), 32'd7);
        chk("full_no_start", 32'(start_cnt - s0), 32'd0);

        // Reset while a pop waits on the heap.
        @(negedge clk);
        req_valid[1]  = 1'b1;
        req_op[3:2]   = OP_POP;
        #1;
        cyc = 0;
        while (!req_ready[1] && cyc < 100) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        repeat (3) @(negedge clk);
        chk("wait_instr", 32'(heap_instr), 32'd2);
        chk("wait_no_start", 32'(heap_start), 32'd0);
        r0 = rsp_cnt;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_instr", 32'(heap_instr), 32'd0);
        chk("mid_rst_err", 32'(rsp_err), 32'd0);
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_start", 32'(heap_start), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("no_rsp_after_rst", 32'(rsp_cnt - r0), 32'd0);
        cmd(1, OP_COUNT, 0, d, e, l);
        chk("count_after_rst", d, 32'd0);
        chk("count_after_rst_err", 32'(e), 32'd0);

`ifdef HEAP_ARB_TIMEOUT_EN
        chk("tmo_flag_clear", 32'(timeout_flag), 32'd0);
        cmd(0, OP_PUSH, 7, d, e, l);
        chk("tmo_push_err", 32'(e), 32'd0);
        stall = 1'b1;
        // accept, CHECK, ISSUE, 16 WAIT cycles, then RESP: 19 cycles.
        cmd(0, OP_POP, 0, d, e, l);
        chk("tmo_err", 32'(e), 32'd1);
        chk("tmo_data", d, 32'hDEAD_0002);
        chk("tmo_lat", 32'(l), 32'(TIMEOUT_CYC + 3));
        chk("tmo_flag", 32'(timeout_flag), 32'd1);
        repeat (5) @(negedge clk);
        chk("tmo_flag_sticky", 32'(timeout_flag), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
